// File: rtl/jerky_pattern_sequencer_if.sv
// rtl/jerky_pattern_sequencer_if.sv - control/status bundle for jerky_pattern_sequencer
//
// Purpose: groups the run-control inputs and the pattern/status outputs of the
// jerky pattern sequencer so that controller and sequencer share one port.
//
// Signals:
//   start     controller -> sequencer  single-cycle start request
//   stop      controller -> sequencer  abort, highest priority
//   pause     controller -> sequencer  level, freezes the sequence while high
//   div       controller -> sequencer  step period minus one (DIV_W bits)
//   reps      controller -> sequencer  pass count, 0 = free-run (CNT_W bits)
//   pattern   sequencer -> controller  current one-hot display value
//   step_idx  sequencer -> controller  current step, 0..13
//   step      sequencer -> controller  pulse in the cycle the index changes
//   busy      sequencer -> controller  high while running or paused
//   done      sequencer -> controller  pulse when the final pass completes
//   pass_cnt  sequencer -> controller  completed passes since last start
//
// Modports: master (controller side), slave (sequencer side).

interface jerky_pattern_sequencer_if #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 4
);
   logic             start;
   logic             stop;
   logic             pause;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] reps;
   logic [7:0]       pattern;
   logic [3:0]       step_idx;
   logic             step;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pass_cnt;

   modport master (
      output start, stop, pause, div, reps,
      input  pattern, step_idx, step, busy, done, pass_cnt
   );

   modport slave (
      input  start, stop, pause, div, reps,
      output pattern, step_idx, step, busy, done, pass_cnt
   );
endinterface

// File: rtl/jerky_pattern_sequencer.sv
// rtl/jerky_pattern_sequencer.sv - run-controlled 14-step jerky one-hot pattern sequencer
//
// Purpose: steps through 128,64,128,32,...,128,1 with start/stop/pause control,
// a programmable step period (div+1 clocks) and an optional pass count.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous, active-high reset
//   bus   slave modport of jerky_pattern_sequencer_if
//         (start/stop/pause/div/reps in; pattern/step_idx/step/busy/done/pass_cnt out)

module jerky_pattern_sequencer #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   jerky_pattern_sequencer_if.slave   bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0] LAST_IDX = 4'd13;

   logic [1:0]       state,     state_d;
   logic [3:0]       step_idx,  idx_d;
   logic [DIV_W-1:0] prescaler, pre_d;
   logic [DIV_W-1:0] div_q,     div_d;
   logic [CNT_W-1:0] reps_q,    reps_d;
   logic [CNT_W-1:0] pass_cnt,  pass_d;
   logic             step_q,    step_d;

   logic             tick;
   logic [CNT_W-1:0] pass_inc;

   assign tick     = (prescaler == div_q);
   assign pass_inc = pass_cnt + CNT_W'(1);

   always_comb begin
      state_d = state;
      idx_d   = step_idx;
      pre_d   = prescaler;
      div_d   = div_q;
      reps_d  = reps_q;
      pass_d  = pass_cnt;
      step_d  = 1'b0;

      if (bus.stop) begin
         // pass_cnt deliberately survives an abort until the next start
         state_d = S_IDLE;
         idx_d   = 4'd0;
         pre_d   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state_d = S_RUN;
                  idx_d   = 4'd0;
                  pre_d   = '0;
                  pass_d  = '0;
                  div_d   = bus.div;
                  reps_d  = bus.reps;
               end
            end

            // The block is frozen on every edge where pause is high. The edge
            // that leaves PAUSE already counts, so each paused cycle costs
            // exactly one cycle of run time.
            S_RUN, S_PAUSE: begin
               if (bus.pause) begin
                  state_d = S_PAUSE;
               end else begin
                  state_d = S_RUN;
                  if (!tick) begin
                     pre_d = prescaler + DIV_W'(1);
                  end else begin
                     pre_d = '0;
                     if (step_idx != LAST_IDX) begin
                        idx_d  = step_idx + 4'd1;
                        step_d = 1'b1;
                     end else begin
                        pass_d = pass_inc;
                        if ((reps_q != '0) && (pass_inc == reps_q)) begin
                           // final pass: index stays on 13, no step pulse
                           state_d = S_DONE;
                        end else begin
                           idx_d  = 4'd0;
                           step_d = 1'b1;
                        end
                     end
                  end
               end
            end

            S_DONE: begin
               state_d = S_IDLE;
               idx_d   = 4'd0;
               pre_d   = '0;
            end

            default: begin
               state_d = S_IDLE;
               idx_d   = 4'd0;
               pre_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         step_idx  <= 4'd0;
         prescaler <= '0;
         div_q     <= '0;
         reps_q    <= '0;
         pass_cnt  <= '0;
         step_q    <= 1'b0;
      end else begin
         state     <= state_d;
         step_idx  <= idx_d;
         prescaler <= pre_d;
         div_q     <= div_d;
         reps_q    <= reps_d;
         pass_cnt  <= pass_d;
         step_q    <= step_d;
      end
   end

   // Pattern is a pure decode of registered state and index, so it only
   // changes after a clock edge. Odd index k maps to 128 >> ((k+1)/2).
   logic [3:0] shamt;
   logic [7:0] pattern;

   assign shamt = (step_idx + 4'd1) >> 1;

   always_comb begin
      pattern = 8'd0;
      if (state != S_IDLE) begin
         if (step_idx[0] == 1'b0) begin
            pattern = 8'd128;
         end else begin
            pattern = 8'd128 >> shamt;
         end
      end
   end

   assign bus.pattern  = pattern;
   assign bus.step_idx = step_idx;
   assign bus.step     = step_q;
   assign bus.busy     = (state == S_RUN) || (state == S_PAUSE);
   assign bus.done     = (state == S_DONE);
   assign bus.pass_cnt = pass_cnt;

endmodule

// File: tb/tb_jerky_pattern_sequencer.sv
// tb/tb_jerky_pattern_sequencer.sv - directed self-checking bench for jerky_pattern_sequencer

module tb_jerky_pattern_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   jerky_pattern_sequencer_if #(.DIV_W(8), .CNT_W(4)) bus ();

   jerky_pattern_sequencer #(.DIV_W(8), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_pat [14] = '{128, 64, 128, 32, 128, 16, 128, 8, 128, 4, 128, 2, 128, 1};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // advance one clock; inputs are driven and outputs sampled 1ns after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // start sampled on the next edge (edge 0); returns in cycle 1
   task automatic do_start(input logic [7:0] d, input logic [3:0] r);
      bus.div   = d;
      bus.reps  = r;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   initial begin
      int c;
      int done_seen;

      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.pause = 1'b0;
      bus.div   = 8'd0;
      bus.reps  = 4'd0;

      // reset state
      repeat (3) cyc();
      check("rst_pattern",  32'(bus.pattern),  32'd0);
      check("rst_step_idx", 32'(bus.step_idx), 32'd0);
      check("rst_step",     32'(bus.step),     32'd0);
      check("rst_busy",     32'(bus.busy),     32'd0);
      check("rst_done",     32'(bus.done),     32'd0);
      check("rst_pass_cnt", 32'(bus.pass_cnt), 32'd0);
      rst = 1'b0;
      cyc();

      // div=0 reps=1: full pattern, step on cycles 2..14, done on 15, idle on 16
      do_start(8'd0, 4'd1);
      check("t1_busy", 32'(bus.busy), 32'd1);
      for (int k = 1; k <= 14; k++) begin
         check($sformatf("t1_pat_c%0d", k),  32'(bus.pattern),  32'(exp_pat[k-1]));
         check($sformatf("t1_step_c%0d", k), 32'(bus.step),     (k >= 2) ? 32'd1 : 32'd0);
         check($sformatf("t1_idx_c%0d", k),  32'(bus.step_idx), 32'(k - 1));
         check($sformatf("t1_done_c%0d", k), 32'(bus.done),     32'd0);
         cyc();
      end
      check("t1_done_c15", 32'(bus.done),     32'd1);
      check("t1_busy_c15", 32'(bus.busy),     32'd0);
      check("t1_step_c15", 32'(bus.step),     32'd0);
      check("t1_pass_c15", 32'(bus.pass_cnt), 32'd1);
      cyc();
      check("t1_pat_c16",  32'(bus.pattern),  32'd0);
      check("t1_done_c16", 32'(bus.done),     32'd0);

      // div=3 reps=2: each index held 4 cycles, done after 112 cycles
      do_start(8'd3, 4'd2);
      for (c = 1; c <= 112; c++) begin
         check($sformatf("t2_idx_c%0d", c),  32'(bus.step_idx), 32'(((c - 1) / 4) % 14));
         check($sformatf("t2_step_c%0d", c), 32'(bus.step),
               ((c >= 5) && ((c - 1) % 4 == 0)) ? 32'd1 : 32'd0);
         check($sformatf("t2_done_c%0d", c), 32'(bus.done), 32'd0);
         if (c == 56) check("t2_pass_c56", 32'(bus.pass_cnt), 32'd0);
         if (c == 57) check("t2_pass_c57", 32'(bus.pass_cnt), 32'd1);
         cyc();
      end
      check("t2_done_c113", 32'(bus.done),     32'd1);
      check("t2_busy_c113", 32'(bus.busy),     32'd0);
      check("t2_pass_c113", 32'(bus.pass_cnt), 32'd2);
      cyc();

      // div=2 reps=1, pause high on edges 5..9 (index 1, prescaler 1)
      do_start(8'd2, 4'd1);
      repeat (4) cyc();
      check("t3_idx_c5", 32'(bus.step_idx), 32'd1);
      bus.pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check($sformatf("t3_pidx_%0d", i),  32'(bus.step_idx), 32'd1);
         check($sformatf("t3_pbusy_%0d", i), 32'(bus.busy),     32'd1);
         check($sformatf("t3_pstep_%0d", i), 32'(bus.step),     32'd0);
      end
      bus.pause = 1'b0;
      cyc();
      check("t3_idx_c11",  32'(bus.step_idx), 32'd1);
      cyc();
      check("t3_idx_c12",  32'(bus.step_idx), 32'd2);
      check("t3_step_c12", 32'(bus.step),     32'd1);
      c = 12;
      while (!bus.done && c < 200) begin
         cyc();
         c++;
      end
      check("t3_done_cycle", 32'(c),            32'd48);
      check("t3_busy_done",  32'(bus.busy),     32'd0);
      check("t3_pass_done",  32'(bus.pass_cnt), 32'd1);
      cyc();

      // stop at step_idx 6, then a normal restart
      do_start(8'd0, 4'd1);
      repeat (6) cyc();
      check("t4_idx_c7", 32'(bus.step_idx), 32'd6);
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      check("t4_pat_stop",  32'(bus.pattern),  32'd0);
      check("t4_busy_stop", 32'(bus.busy),     32'd0);
      check("t4_done_stop", 32'(bus.done),     32'd0);
      check("t4_idx_stop",  32'(bus.step_idx), 32'd0);
      done_seen = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (bus.done) done_seen++;
      end
      check("t4_no_done", 32'(done_seen), 32'd0);
      do_start(8'd0, 4'd1);
      check("t4_restart_pat",  32'(bus.pattern), 32'd128);
      check("t4_restart_busy", 32'(bus.busy),    32'd1);
      c = 1;
      while (!bus.done && c < 100) begin
         cyc();
         c++;
      end
      check("t4_restart_done_cycle", 32'(c), 32'd15);
      cyc();

      // free-run: pass_cnt wraps 15 -> 0, done never asserts
      do_start(8'd0, 4'd0);
      done_seen = 0;
      for (c = 1; c <= 229; c++) begin
         if (bus.done) done_seen++;
         if (c == 211) check("t5_pass_c211", 32'(bus.pass_cnt), 32'd15);
         if (c == 224) check("t5_pass_c224", 32'(bus.pass_cnt), 32'd15);
         if (c == 225) check("t5_pass_c225", 32'(bus.pass_cnt), 32'd0);
         if (c == 225) check("t5_idx_c225",  32'(bus.step_idx), 32'd0);
         cyc();
      end
      check("t5_no_done",  32'(done_seen),     32'd0);
      check("t5_idx_c230", 32'(bus.step_idx), 32'd5);
      do_start(8'd5, 4'd3);
      check("t5_busy_start_idx", 32'(bus.step_idx), 32'd6);
      check("t5_busy_start_stp", 32'(bus.step),     32'd1);
      cyc();
      check("t5_div_unchanged",  32'(bus.step_idx), 32'd7);
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      cyc();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check("t5_ss_busy", 32'(bus.busy),    32'd0);
      check("t5_ss_pat",  32'(bus.pattern), 32'd0);
      cyc();
      check("t5_ss_busy2", 32'(bus.busy), 32'd0);

      // asynchronous reset at step_idx 9
      do_start(8'd0, 4'd1);
      repeat (9) cyc();
      check("t6_idx_c10", 32'(bus.step_idx), 32'd9);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_pat",  32'(bus.pattern),  32'd0);
      check("t6_rst_idx",  32'(bus.step_idx), 32'd0);
      check("t6_rst_step", 32'(bus.step),     32'd0);
      check("t6_rst_busy", 32'(bus.busy),     32'd0);
      check("t6_rst_done", 32'(bus.done),     32'd0);
      check("t6_rst_pass", 32'(bus.pass_cnt), 32'd0);
      cyc();
      rst = 1'b0;
      cyc();
      do_start(8'd0, 4'd1);
      check("t6_restart_pat1", 32'(bus.pattern), 32'd128);
      cyc();
      check("t6_restart_pat2", 32'(bus.pattern), 32'd64);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
